// File: rtl/dmem_port_arbiter_pkg.sv
// Shared widths, port identifiers and FSM encoding for the dmem port arbiter.
package dmem_port_arbiter_pkg;

    localparam int unsigned ADDR_W       = 12;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned MAX_LOCK_DEF = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester and dmem-side signals of the arbiter; slave = arbiter, master = requesters plus dmem.
interface dmem_port_arbiter_if;
    import dmem_port_arbiter_pkg::*;

    logic              req0, req1;
    logic              lock0, lock1;
    logic              wren0, wren1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  req0, req1, lock0, lock1, wren0, wren1, addr0, addr1, wdata0, wdata1, mem_q,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_address, mem_data, mem_wren
    );

    modport master (
        output req0, req1, lock0, lock1, wren0, wren1, addr0, addr1, wdata0, wdata1, mem_q,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_address, mem_data, mem_wren
    );

endinterface

// File: rtl/dmem_port_arbiter_arb_rr_select.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port that was not granted last.
module arb_rr_select (
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_last,
    output logic [1:0] o_pick_c
);

    assign o_pick_c[0] = i_req0 & (~i_req1 | i_last);
    assign o_pick_c[1] = i_req1 & (~i_req0 | ~i_last);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin dmem arbiter with bounded bus lock, combinational grant/memory mux and registered read return.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic                clock,
    input  logic                reset,
    dmem_port_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_e        r_state;
    logic              r_last;
    logic [CNT_W-1:0]  r_lock_cnt;
    logic              r_rvalid0, r_rvalid1;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;

    logic [1:0]        w_pick;
    logic [1:0]        w_gnt;
    logic              w_sel_lock;
    logic              w_own_port;
    logic              w_own_req;
    logic              w_own_lock;
    logic [CNT_W-1:0]  w_cnt_inc;

    arb_rr_select u_rr (
        .i_req0   (bus.req0),
        .i_req1   (bus.req1),
        .i_last   (r_last),
        .o_pick_c (w_pick)
    );

    assign w_own_port = (r_state == ST_OWN1);
    assign w_own_req  = w_own_port ? bus.req1  : bus.req0;
    assign w_own_lock = w_own_port ? bus.lock1 : bus.lock0;
    assign w_sel_lock = w_gnt[1]   ? bus.lock1 : bus.lock0;
    assign w_cnt_inc  = r_lock_cnt + CNT_W'(1);

    // Owner-only grant while locked; everything is forced quiet while reset is asserted.
    always_comb begin
        w_gnt = 2'b00;
        unique case (r_state)
            ST_IDLE: w_gnt = w_pick;
            ST_OWN0: w_gnt = {1'b0, bus.req0};
            ST_OWN1: w_gnt = {bus.req1, 1'b0};
            default: w_gnt = 2'b00;
        endcase
        if (!reset) begin
            w_gnt = 2'b00;
        end
    end

    assign bus.gnt0        = w_gnt[0];
    assign bus.gnt1        = w_gnt[1];
    assign bus.mem_address = w_gnt[1] ? bus.addr1  : bus.addr0;
    assign bus.mem_data    = w_gnt[1] ? bus.wdata1 : bus.wdata0;
    assign bus.mem_wren    = (w_gnt[0] & bus.wren0) | (w_gnt[1] & bus.wren1);
    assign bus.rvalid0     = r_rvalid0;
    assign bus.rvalid1     = r_rvalid1;
    assign bus.rdata0      = r_rdata0;
    assign bus.rdata1      = r_rdata1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_last     <= PORT_DBG;
            r_lock_cnt <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_rvalid0 <= w_gnt[0] & ~bus.wren0;
            r_rvalid1 <= w_gnt[1] & ~bus.wren1;
            if (w_gnt[0] && !bus.wren0) begin
                r_rdata0 <= bus.mem_q;
            end
            if (w_gnt[1] && !bus.wren1) begin
                r_rdata1 <= bus.mem_q;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_last <= w_gnt[1];
                        // A limit of one means the lock is already exhausted by this grant.
                        if (w_sel_lock && (MAX_LOCK > 1)) begin
                            r_state    <= w_gnt[1] ? ST_OWN1 : ST_OWN0;
                            r_lock_cnt <= CNT_W'(1);
                        end
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (w_own_req) begin
                        r_last <= w_own_port;
                    end
                    if (!w_own_req || !w_own_lock || (w_cnt_inc == CNT_W'(MAX_LOCK))) begin
                        r_state    <= ST_IDLE;
                        r_lock_cnt <= '0;
                    end else begin
                        r_lock_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_lock_cnt <= '0;
                end
            endcase
        end
    end

endmodule
